// File: rtl/fft_pkg.sv
// Shared types and helpers for the radix-2 butterfly page: complex/twiddle
// words, their packing, and the clip-to-range saturation used on results.
package fft_pkg;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_TW_W   = 16;
  localparam int SAT_W      = 64;

  typedef struct packed {
    logic signed [DEF_DATA_W-1:0] re;
    logic signed [DEF_DATA_W-1:0] im;
  } cplx_t;

  typedef struct packed {
    logic signed [DEF_TW_W-1:0] re;
    logic signed [DEF_TW_W-1:0] im;
  } twiddle_t;

  function automatic logic [2*DEF_DATA_W-1:0] pack_cplx(input cplx_t c);
    return {c.re, c.im};
  endfunction

  function automatic cplx_t unpack_cplx(input logic [2*DEF_DATA_W-1:0] w);
    return cplx_t'(w);
  endfunction

  function automatic logic [2*DEF_TW_W-1:0] pack_twiddle(input twiddle_t t);
    return {t.re, t.im};
  endfunction

  function automatic twiddle_t unpack_twiddle(input logic [2*DEF_TW_W-1:0] w);
    return twiddle_t'(w);
  endfunction

  // Clips a sign-extended value into the signed range of a w-bit word.
  function automatic logic signed [SAT_W-1:0] saturate(input logic signed [SAT_W-1:0] v,
                                                       input int w);
    logic signed [SAT_W-1:0] hi;
    logic signed [SAT_W-1:0] lo;
    hi = (SAT_W'(1) <<< (w - 1)) - SAT_W'(1);
    lo = -(SAT_W'(1) <<< (w - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  function automatic logic sat_hit(input logic signed [SAT_W-1:0] v, input int w);
    return saturate(v, w) != v;
  endfunction

endpackage

// File: rtl/fft_bfly_core.sv
// One butterfly through the multiply stage (S2) and the add/scale/saturate
// stage (S3); the page feeds it registered S1 operands.
module fft_bfly_core
  import fft_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int TW_W   = DEF_TW_W
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     enable_i,
  input  logic                     load_i,
  input  logic                     scale_i,
  input  logic signed [DATA_W-1:0] aRe_i,
  input  logic signed [DATA_W-1:0] aIm_i,
  input  logic signed [DATA_W-1:0] bRe_i,
  input  logic signed [DATA_W-1:0] bIm_i,
  input  logic signed [TW_W-1:0]   wRe_i,
  input  logic signed [TW_W-1:0]   wIm_i,
  output logic [2*DATA_W-1:0]      top_o,
  output logic [2*DATA_W-1:0]      bottom_o,
  output logic                     sat_o
);

  localparam int PW = DATA_W + TW_W + 1;
  localparam int KW = DATA_W + 2;
  localparam int SW = DATA_W + 3;
  localparam logic signed [PW-1:0] ROUND = PW'(1) <<< (TW_W - 2);

  logic signed [PW-1:0]     prFull, piFull;
  logic signed [KW-1:0]     pRe_d, pIm_d, pRe_q, pIm_q;
  logic signed [DATA_W-1:0] aRe_q, aIm_q;
  logic signed [SW-1:0]     tRe, tIm, uRe, uIm;
  logic [2*DATA_W-1:0]      top_d, bottom_d, top_q, bottom_q;

  function automatic logic signed [SW-1:0] halve(input logic signed [SW-1:0] x,
                                                 input logic s);
    return s ? ((x + SW'(1)) >>> 1) : x;
  endfunction

  // PW bits are enough for (-1.0)*(-1.0) plus the cross term without wrapping.
  always_comb begin
    prFull = PW'(bRe_i) * PW'(wRe_i) - PW'(bIm_i) * PW'(wIm_i);
    piFull = PW'(bRe_i) * PW'(wIm_i) + PW'(bIm_i) * PW'(wRe_i);
    pRe_d  = KW'((prFull + ROUND) >>> (TW_W - 1));
    pIm_d  = KW'((piFull + ROUND) >>> (TW_W - 1));
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pRe_q <= '0;
      pIm_q <= '0;
      aRe_q <= '0;
      aIm_q <= '0;
    end else if (enable_i) begin
      pRe_q <= pRe_d;
      pIm_q <= pIm_d;
      aRe_q <= aRe_i;
      aIm_q <= aIm_i;
    end
  end

  always_comb begin
    tRe = halve(SW'(aRe_q) + SW'(pRe_q), scale_i);
    tIm = halve(SW'(aIm_q) + SW'(pIm_q), scale_i);
    uRe = halve(SW'(aRe_q) - SW'(pRe_q), scale_i);
    uIm = halve(SW'(aIm_q) - SW'(pIm_q), scale_i);
    top_d    = {DATA_W'(saturate(SAT_W'(tRe), DATA_W)),
                DATA_W'(saturate(SAT_W'(tIm), DATA_W))};
    bottom_d = {DATA_W'(saturate(SAT_W'(uRe), DATA_W)),
                DATA_W'(saturate(SAT_W'(uIm), DATA_W))};
    sat_o    = sat_hit(SAT_W'(tRe), DATA_W) | sat_hit(SAT_W'(tIm), DATA_W) |
               sat_hit(SAT_W'(uRe), DATA_W) | sat_hit(SAT_W'(uIm), DATA_W);
  end

  // Results only move when a valid vector lands; bubbles leave them intact.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      top_q    <= '0;
      bottom_q <= '0;
    end else if (enable_i && load_i) begin
      top_q    <= top_d;
      bottom_q <= bottom_d;
    end
  end

  assign top_o    = top_q;
  assign bottom_o = bottom_q;

endmodule

// File: rtl/fft_bfly_page.sv
// Radix-2 FFT page: NUM_BFLY butterflies, 3-stage pipeline with enable,
// optional divide-by-2, saturation with sticky overflow and a result counter.
module fft_bfly_page
  import fft_pkg::*;
#(
  parameter int NUM_BFLY = 4,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int TW_W     = DEF_TW_W
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         i_enable,
  input  logic                         i_valid,
  input  logic                         i_scale,
  input  logic                         i_clear_ovf,
  input  logic [NUM_BFLY*2*DATA_W-1:0] i_top,
  input  logic [NUM_BFLY*2*DATA_W-1:0] i_bottom,
  input  logic [NUM_BFLY*2*TW_W-1:0]   i_twiddle,
  output logic [NUM_BFLY*2*DATA_W-1:0] o_write_val1,
  output logic [NUM_BFLY*2*DATA_W-1:0] o_write_val2,
  output logic                         o_valid,
  output logic                         o_overflow,
  output logic [15:0]                  o_frame_count
);

  localparam int CW = 2 * DATA_W;
  localparam int WW = 2 * TW_W;

  logic [NUM_BFLY*CW-1:0] top_q, bottom_q;
  logic [NUM_BFLY*WW-1:0] tw_q;
  logic                   valid1_q, scale1_q, valid2_q, scale2_q, valid3_q;
  logic                   ovf_d, ovf_q;
  logic [15:0]            frames_d, frames_q;
  logic [NUM_BFLY-1:0]    satVec;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      top_q    <= '0;
      bottom_q <= '0;
      tw_q     <= '0;
      valid1_q <= 1'b0;
      scale1_q <= 1'b0;
      valid2_q <= 1'b0;
      scale2_q <= 1'b0;
      valid3_q <= 1'b0;
      ovf_q    <= 1'b0;
      frames_q <= '0;
    end else if (i_enable) begin
      top_q    <= i_top;
      bottom_q <= i_bottom;
      tw_q     <= i_twiddle;
      valid1_q <= i_valid;
      scale1_q <= i_scale;
      valid2_q <= valid1_q;
      scale2_q <= scale1_q;
      valid3_q <= valid2_q;
      ovf_q    <= ovf_d;
      frames_q <= frames_d;
    end
  end

  for (genvar k = 0; k < NUM_BFLY; k++) begin : g_bfly
    fft_bfly_core #(
      .DATA_W(DATA_W),
      .TW_W  (TW_W)
    ) u_core (
      .clock   (clock),
      .reset   (reset),
      .enable_i(i_enable),
      .load_i  (valid2_q),
      .scale_i (scale2_q),
      .aRe_i   (top_q[CW*k+DATA_W +: DATA_W]),
      .aIm_i   (top_q[CW*k +: DATA_W]),
      .bRe_i   (bottom_q[CW*k+DATA_W +: DATA_W]),
      .bIm_i   (bottom_q[CW*k +: DATA_W]),
      .wRe_i   (tw_q[WW*k+TW_W +: TW_W]),
      .wIm_i   (tw_q[WW*k +: TW_W]),
      .top_o   (o_write_val1[CW*k +: CW]),
      .bottom_o(o_write_val2[CW*k +: CW]),
      .sat_o   (satVec[k])
    );
  end

  // Flag and counter update on the edge a valid vector enters S3, so they
  // change together with o_valid; a coinciding set beats the clear.
  always_comb begin
    ovf_d    = ovf_q;
    frames_d = frames_q;
    if (i_clear_ovf) ovf_d = 1'b0;
    if (valid2_q) begin
      frames_d = frames_q + 16'd1;
      if (|satVec) ovf_d = 1'b1;
    end
  end

  assign o_valid       = valid3_q;
  assign o_overflow    = ovf_q;
  assign o_frame_count = frames_q;

endmodule
